// File: rtl/ternary_weight_unload_if.sv
// ---------------------------------------------------------------------------
// ternary_weight_unload_if
// Beat stream from the weight readback engine to the output mux.
//   uo_data  : current 16-bit chunk of the weight bank (0 when not valid)
//   uo_valid : uo_data holds a beat
//   ui_ready : downstream accepts the beat at the next clk edge
// master = readback engine, slave = downstream consumer.
// ---------------------------------------------------------------------------
interface ternary_weight_unload_if #(
   parameter int MAX_IN_LEN = 16
);
   logic [MAX_IN_LEN-1:0] uo_data;
   logic                  uo_valid;
   logic                  ui_ready;

   modport master (output uo_data, output uo_valid, input ui_ready);
   modport slave  (input uo_data, input uo_valid, output ui_ready);
endinterface

// File: rtl/ternary_weight_unload.sv
// ---------------------------------------------------------------------------
// ternary_weight_unload
// Snapshots the packed ternary weight bank and streams it out one
// MAX_IN_LEN-bit beat per accepted handshake, lowest chunk first, in the
// same chunk order and row encoding the loader uses.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   ena         : global enable, low freezes every register
//   start       : readback request, honoured only in IDLE
//   ui_param    : low MAX_OUT_BITS bits = rows - 1
//   ui_weights  : packed weight bank, captured on the start cycle
//   stream      : beat stream (uo_data / uo_valid / ui_ready)
//   uo_busy     : high while beats are being offered
//   uo_done     : one-cycle pulse after the last beat is accepted
// ---------------------------------------------------------------------------
module ternary_weight_unload #(
   parameter int MAX_IN_LEN   = 16,
   parameter int MAX_OUT_LEN  = 8,
   parameter int WIDTH        = 2,
   parameter int MAX_IN_BITS  = $clog2(MAX_IN_LEN),
   parameter int MAX_OUT_BITS = $clog2(MAX_OUT_LEN),
   parameter int WIDTH_BITS   = $clog2(WIDTH)
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      ena,
   input  logic                                      start,
   input  logic [MAX_IN_BITS+MAX_OUT_BITS-1:0]       ui_param,
   input  logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0]   ui_weights,
   ternary_weight_unload_if.master                   stream,
   output logic                                      uo_busy,
   output logic                                      uo_done
);

   localparam int NUM_BEATS = WIDTH * MAX_OUT_LEN;
   localparam int CNT_W     = MAX_OUT_BITS + WIDTH_BITS;
   localparam int BANK_W    = WIDTH * MAX_IN_LEN * MAX_OUT_LEN;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                  state_r,  state_nx_s;
   logic [CNT_W-1:0]        count_r,  count_nx_s;
   logic [MAX_OUT_BITS-1:0] rows_r,   rows_nx_s;
   logic [BANK_W-1:0]       shadow_r, shadow_nx_s;
   logic [MAX_IN_LEN-1:0]   data_r,   data_nx_s;
   logic                    valid_r,  valid_nx_s;
   logic                    busy_r,   busy_nx_s;
   logic                    done_r,   done_nx_s;

   logic [MAX_IN_LEN-1:0]   beat_s [NUM_BEATS];
   logic [CNT_W-1:0]        last_s;
   logic [CNT_W-1:0]        count_inc_s;
   logic                    accept_s;
   logic                    param_unused_s;

   // Only the row field of ui_param matters to readback.
   assign param_unused_s = ^ui_param[MAX_IN_BITS+MAX_OUT_BITS-1:MAX_OUT_BITS];

   // Final beat index: row number in the high bits, all-ones chunk index below.
   assign last_s      = {rows_r, {WIDTH_BITS{1'b1}}};
   assign count_inc_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
   assign accept_s    = valid_r & stream.ui_ready & ena;

   // View the shadow bank as an array of beats for indexed selection.
   always_comb begin
      for (int i = 0; i < NUM_BEATS; i++) begin
         beat_s[i] = shadow_r[i*MAX_IN_LEN +: MAX_IN_LEN];
      end
   end

   // Next-state and next-output logic; everything holds unless ena is high.
   always_comb begin
      state_nx_s  = state_r;
      count_nx_s  = count_r;
      rows_nx_s   = rows_r;
      shadow_nx_s = shadow_r;
      data_nx_s   = data_r;
      valid_nx_s  = valid_r;
      busy_nx_s   = busy_r;
      done_nx_s   = done_r;
      if (ena) begin
         case (state_r)
            ST_IDLE: begin
               valid_nx_s = 1'b0;
               busy_nx_s  = 1'b0;
               done_nx_s  = 1'b0;
               data_nx_s  = '0;
               if (start) begin
                  state_nx_s  = ST_SEND;
                  shadow_nx_s = ui_weights;
                  rows_nx_s   = ui_param[MAX_OUT_BITS-1:0];
                  count_nx_s  = '0;
                  data_nx_s   = ui_weights[MAX_IN_LEN-1:0];
                  valid_nx_s  = 1'b1;
                  busy_nx_s   = 1'b1;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end
            ST_SEND: begin
               if (accept_s) begin
                  if (count_r == last_s) begin
                     state_nx_s = ST_DONE;
                     valid_nx_s = 1'b0;
                     busy_nx_s  = 1'b0;
                     done_nx_s  = 1'b1;
                     data_nx_s  = '0;
                  end else begin
                     count_nx_s = count_inc_s;
                     data_nx_s  = beat_s[count_inc_s];
                  end
               end else begin
                  state_nx_s = ST_SEND;
               end
            end
            ST_DONE: begin
               state_nx_s = ST_IDLE;
               done_nx_s  = 1'b0;
               valid_nx_s = 1'b0;
               busy_nx_s  = 1'b0;
               data_nx_s  = '0;
            end
            default: begin
               state_nx_s = ST_IDLE;
               count_nx_s = '0;
               valid_nx_s = 1'b0;
               busy_nx_s  = 1'b0;
               done_nx_s  = 1'b0;
               data_nx_s  = '0;
            end
         endcase
      end else begin
         state_nx_s = state_r;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         count_r  <= '0;
         rows_r   <= '0;
         shadow_r <= '0;
         data_r   <= '0;
         valid_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         count_r  <= count_nx_s;
         rows_r   <= rows_nx_s;
         shadow_r <= shadow_nx_s;
         data_r   <= data_nx_s;
         valid_r  <= valid_nx_s;
         busy_r   <= busy_nx_s;
         done_r   <= done_nx_s;
      end
   end

   assign stream.uo_data  = data_r;
   assign stream.uo_valid = valid_r;
   assign uo_busy         = busy_r;
   assign uo_done         = done_r;

endmodule

// File: tb/tb_ternary_weight_unload.sv
// ---------------------------------------------------------------------------
// tb_ternary_weight_unload
// Directed bench for the weight readback engine. Inputs change 1 ns after
// the rising edge and outputs are sampled at the same point, so each sample
// reflects the edge just taken.
// ---------------------------------------------------------------------------
module tb_ternary_weight_unload;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ena;
   logic         start;
   logic [6:0]   ui_param;
   logic [255:0] ui_weights;
   logic         uo_busy;
   logic         uo_done;

   int checks = 0;
   int errors = 0;

   ternary_weight_unload_if #(.MAX_IN_LEN(16)) stream ();

   ternary_weight_unload dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .start      (start),
      .ui_param   (ui_param),
      .ui_weights (ui_weights),
      .stream     (stream),
      .uo_busy    (uo_busy),
      .uo_done    (uo_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] pattern_weights();
      logic [255:0] w;
      w = '0;
      for (int k = 0; k < 16; k++) begin
         w[k*16 +: 16] = 16'hA500 + 16'(k);
      end
      return w;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; stream.ui_ready = 1'b1; ena = 1'b1;
      ui_param = 7'd7; ui_weights = pattern_weights();
      tick(); tick();
      checks++;
      if (stream.uo_valid !== 1'b0 || uo_busy !== 1'b0 || uo_done !== 1'b0
          || stream.uo_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset: valid=%b busy=%b done=%b data=%h expected 0 0 0 0000",
                  stream.uo_valid, uo_busy, uo_done, stream.uo_data);
      end
      start = 1'b0; rst_n = 1'b1;
      tick();
   endtask

   // Stream (rows+1)*2 beats with ready high, then check the done pulse.
   task automatic run_burst(input logic [2:0] rows, input string name);
      int nbeats;
      nbeats = (int'(rows) + 1) * 2;
      ui_param = {4'd0, rows}; ui_weights = pattern_weights();
      stream.ui_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < nbeats; k++) begin
         checks++;
         if (stream.uo_valid !== 1'b1 || uo_busy !== 1'b1 || uo_done !== 1'b0
             || stream.uo_data !== 16'hA500 + 16'(k)) begin
            errors++;
            $display("FAIL %s beat %0d: valid=%b busy=%b done=%b data=%h expected data %h",
                     name, k, stream.uo_valid, uo_busy, uo_done, stream.uo_data,
                     16'hA500 + 16'(k));
         end
         tick();
      end
      checks++;
      if (uo_done !== 1'b1 || stream.uo_valid !== 1'b0 || stream.uo_data !== 16'h0000) begin
         errors++;
         $display("FAIL %s done: done=%b valid=%b data=%h expected 1 0 0000",
                  name, uo_done, stream.uo_valid, stream.uo_data);
      end
      tick();
      checks++;
      if (uo_done !== 1'b0 || uo_busy !== 1'b0 || stream.uo_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s idle: done=%b busy=%b valid=%b expected 0 0 0",
                  name, uo_done, uo_busy, stream.uo_valid);
      end
   endtask

   task automatic test_full_burst();
      run_burst(3'd7, "full_burst");
   endtask

   task automatic test_short_burst();
      run_burst(3'd0, "short_burst");
   endtask

   task automatic test_backpressure();
      logic [15:0] exp_tab   [9];
      logic        ready_tab [9];
      logic        ena_tab   [9];
      exp_tab   = '{16'hA500, 16'hA501, 16'hA501, 16'hA501, 16'hA501,
                    16'hA502, 16'hA502, 16'hA502, 16'hA503};
      ready_tab = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      ena_tab   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      ui_param = {4'd0, 3'd1}; ui_weights = pattern_weights();
      stream.ui_ready = 1'b1; ena = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (stream.uo_valid !== 1'b1 || uo_done !== 1'b0 || stream.uo_data !== exp_tab[i]) begin
            errors++;
            $display("FAIL backpressure cycle %0d: valid=%b done=%b data=%h expected 1 0 %h",
                     i, stream.uo_valid, uo_done, stream.uo_data, exp_tab[i]);
         end
         stream.ui_ready = ready_tab[i];
         ena = ena_tab[i];
         tick();
      end
      checks++;
      if (uo_done !== 1'b1 || stream.uo_valid !== 1'b0) begin
         errors++;
         $display("FAIL backpressure done: done=%b valid=%b expected 1 0",
                  uo_done, stream.uo_valid);
      end
      ena = 1'b1; stream.ui_ready = 1'b1;
      tick();
   endtask

   task automatic test_snapshot();
      int done_seen;
      done_seen = 0;
      ui_param = {4'd0, 3'd1}; ui_weights = pattern_weights();
      stream.ui_ready = 1'b1; start = 1'b1;
      tick();
      ui_weights = {256{1'b1}};
      ui_param = 7'h7F;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (stream.uo_valid !== 1'b1 || stream.uo_data !== 16'hA500 + 16'(k)) begin
            errors++;
            $display("FAIL snapshot beat %0d: valid=%b data=%h expected 1 %h",
                     k, stream.uo_valid, stream.uo_data, 16'hA500 + 16'(k));
         end
         tick();
      end
      start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (uo_done === 1'b1) done_seen++;
         checks++;
         if (c > 0 && stream.uo_valid !== 1'b0) begin
            errors++;
            $display("FAIL snapshot restart cycle %0d: valid=%b expected 0", c, stream.uo_valid);
         end
         tick();
      end
      checks++;
      if (done_seen != 1) begin
         errors++;
         $display("FAIL snapshot done count: got %0d expected 1", done_seen);
      end
      ui_weights = pattern_weights();
   endtask

   task automatic test_reset_mid();
      ui_param = {4'd0, 3'd7}; ui_weights = pattern_weights();
      stream.ui_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (stream.uo_data !== 16'hA500 + 16'(k)) begin
            errors++;
            $display("FAIL reset_mid beat %0d: data=%h expected %h",
                     k, stream.uo_data, 16'hA500 + 16'(k));
         end
         tick();
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (stream.uo_valid !== 1'b0 || uo_busy !== 1'b0 || uo_done !== 1'b0
          || stream.uo_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_mid flush: valid=%b busy=%b done=%b data=%h expected 0 0 0 0000",
                  stream.uo_valid, uo_busy, uo_done, stream.uo_data);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (uo_done !== 1'b0 || stream.uo_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid quiet cycle %0d: done=%b valid=%b expected 0 0",
                     c, uo_done, stream.uo_valid);
         end
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (stream.uo_valid !== 1'b1 || stream.uo_data !== 16'hA500) begin
         errors++;
         $display("FAIL reset_mid restart: valid=%b data=%h expected 1 a500",
                  stream.uo_valid, stream.uo_data);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_full_burst();
      test_short_burst();
      test_backpressure();
      test_snapshot();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ternary_weight_unload.md
# ternary_weight_unload

Parallel-to-serial readback engine for the ternary weight bank. It snapshots the packed weight vector produced by the weight loader and streams it out 16 bits per beat over a valid/ready interface. Chunk order and row-count encoding match the loader exactly, so a loaded bank can be dumped for debug/verification or forwarded to another tile. It sits between the weight register bank and the output mux.

## Interface
- MAX_IN_LEN, 16, inputs per row; also the beat width in bits
- MAX_OUT_LEN, 8, number of output rows
- WIDTH, 2, bits per ternary weight
- MAX_IN_BITS, $clog2(MAX_IN_LEN), derived
- MAX_OUT_BITS, $clog2(MAX_OUT_LEN), derived
- WIDTH_BITS, $clog2(WIDTH), derived
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  global enable; low freezes all state
- start  in  1  request a readback; sampled only in IDLE
- ui_param  in  MAX_IN_BITS+MAX_OUT_BITS  configuration; low MAX_OUT_BITS bits = number of rows minus 1
- ui_weights  in  WIDTH*MAX_IN_LEN*MAX_OUT_LEN  packed weight bank (same layout as loader output)
- ui_ready  in  1  downstream ready
- uo_data  out  MAX_IN_LEN  current beat
- uo_valid  out  1  uo_data valid
- uo_busy  out  1  high in SEND
- uo_done  out  1  one-cycle pulse after last beat accepted

## Operation
- Reset (rst_n low at a clk edge, regardless of ena): state IDLE, count 0, shadow 0, uo_data 0, uo_valid 0, uo_busy 0, uo_done 0.
- All outputs registered. When ena low: no state, counter, shadow or output change; handshakes are not counted even if ui_ready high.
- States: IDLE, SEND, DONE.
- IDLE: on ena && start: copy ui_weights into shadow register, latch rows = ui_param[MAX_OUT_BITS-1:0], count <= 0, go SEND. Otherwise stay.
- SEND: uo_valid=1, uo_busy=1, uo_data = shadow[count*MAX_IN_LEN +: MAX_IN_LEN]. Beat accepted when uo_valid && ui_ready && ena. On accept: if count == {rows, {WIDTH_BITS{1'b1}}} go DONE, else count <= count+1. No accept: count and uo_data hold.
- DONE: uo_valid=0, uo_busy=0, uo_done=1 for exactly one cycle, uo_data=0; unconditionally to IDLE.
- Beats per transfer = (rows+1)*WIDTH; beat k carries weight bits [16k+15:16k]. Beat index is MAX_OUT_BITS+WIDTH_BITS wide; max count (rows=MAX_OUT_LEN-1) is all-ones, so no wrap occurs.
- start outside IDLE ignored (not queued). ui_weights and ui_param changes after the start cycle have no effect on the transfer in progress.
- uo_data is 0 whenever uo_valid is 0.

## Timing
- start sampled at edge N (IDLE, ena=1) -> uo_valid=1, uo_data=beat 0 after edge N.
- ui_ready held high, ena high: beat k visible in cycle N+1+k; last beat in cycle N+C (C=beat count); uo_done=1 in cycle N+C+1; IDLE in cycle N+C+2, earliest next start sampled at edge ending that cycle.
- Each cycle with ready low or ena low adds exactly one cycle of latency; data stable throughout.
- rst_n low mid-transfer: all outputs 0 on following cycle; no uo_done pulse; remaining beats discarded.

## Test plan
- Reset: hold rst_n low 2 cycles with start=1, ui_ready=1 -> uo_valid=0, uo_busy=0, uo_done=0, uo_data=16'h0000.
- Full burst: ui_weights beat k = 16'hA500+k (k=0..15), ui_param low bits=7, ready=1, pulse start -> 16 consecutive beats 16'hA500..16'hA50F, cycles N+1..N+16, uo_done single pulse at N+17.
- Short burst: ui_param low bits=0, same weights -> exactly 2 beats 16'hA500, 16'hA501, then uo_done; higher chunks never appear.
- Backpressure/ena: rows=1, ready low for 3 cycles on beat 1 and ena low 2 cycles on beat 2 -> beat 1 held 16'hA501 for 4 cycles, beat 2 held, total 4 beats, done 5 cycles later than unstalled.
- Snapshot/ignored start: after start, overwrite ui_weights with all-0xFF and pulse start during SEND -> stream still 16'hA5xx values, only one uo_done, no second transfer.
- Reset mid-transfer: rows=7, assert rst_n low after beat 5 accepted -> next cycle uo_valid=0, no uo_done; fresh start then streams from beat 0 (16'hA500).
